vram_arbiter: RTL and testbench

- Shares the single video-memory port between up to NUM_REQ drawing/fetch engines (fill_rect engine, line engine, display fetch).
- Each requester presents one 32-bit memory transaction at a time over an rts/rtr handshake.
- Grants round-robin, registers the winning transaction into a one-entry output stage toward memory, and routes read data back to the issuing requester via an in-order tag FIFO.

---
 rtl/vram_arbiter_if.sv | 39 +++
 rtl/vram_arbiter.sv | 149 ++++++++++++++
 tb/tb_vram_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bundles the requester-side and memory-side buses of the video-memory arbiter.
// slave: the arbiter's view. master: the requester/memory environment's view.
interface vram_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    logic [32*NUM_REQ-1:0] req_in_data;
    logic [16*NUM_REQ-1:0] req_in_addr;
    logic [4*NUM_REQ-1:0]  req_in_wben;
    logic [NUM_REQ-1:0]    req_in_op;
    logic [NUM_REQ-1:0]    req_in_rts;
    logic [NUM_REQ-1:0]    req_out_rtr;
    logic [31:0]           req_out_rdata;
    logic [NUM_REQ-1:0]    req_out_rvalid;
    logic [31:0]           mem_out_data;
    logic [15:0]           mem_out_addr;
    logic [3:0]            mem_out_wben;
    logic                  mem_out_op;
    logic                  mem_out_rts;
    logic                  mem_in_rtr;
    logic [31:0]           mem_in_rdata;
    logic                  mem_in_rvalid;
    logic                  arb_err;

    modport slave (
        input  req_in_data, req_in_addr, req_in_wben, req_in_op, req_in_rts,
        input  mem_in_rtr, mem_in_rdata, mem_in_rvalid,
        output req_out_rtr, req_out_rdata, req_out_rvalid,
        output mem_out_data, mem_out_addr, mem_out_wben, mem_out_op, mem_out_rts,
        output arb_err
    );

    modport master (
        output req_in_data, req_in_addr, req_in_wben, req_in_op, req_in_rts,
        output mem_in_rtr, mem_in_rdata, mem_in_rvalid,
        input  req_out_rtr, req_out_rdata, req_out_rvalid,
        input  mem_out_data, mem_out_addr, mem_out_wben, mem_out_op, mem_out_rts,
        input  arb_err
    );
endinterface

// File: rtl/vram_arbiter.sv
// Round-robin arbiter sharing one video-memory port between NUM_REQ engines, with a
// one-entry registered output stage and an in-order tag FIFO routing read data back.
module vram_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned TAG_DEPTH = 4
) (
    input logic           clk,
    input logic           rst_,
    vram_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);

    typedef logic [IDX_W-1:0] idx_t;

    // Arbitration state
    idx_t             ptr_q;
    logic [CNT_W-1:0] rsv_q, rsv_d;

    // Output stage
    logic             vld_q;
    logic [31:0]      data_q;
    logic [15:0]      addr_q;
    logic [3:0]       wben_q;
    logic             op_q;

    // Tag FIFO and read return
    idx_t             tag_mem [TAG_DEPTH];
    logic [PTR_W:0]   wr_q, rd_q;
    logic             fifo_empty, push, pop;
    idx_t             head;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [31:0]      rdata_q;
    logic             err_q;

    // Grant
    logic               stage_free, rsv_avail, gnt_vld, rsv_inc;
    logic [NUM_REQ-1:0] elig, gnt;
    idx_t               win;
    logic [31:0]        win_data;
    logic [15:0]        win_addr;
    logic [3:0]         win_wben;
    logic               win_op;

    assign stage_free = !vld_q || bus.mem_in_rtr;
    assign rsv_avail  = rsv_q < CNT_W'(TAG_DEPTH);
    assign elig       = bus.req_in_rts & (bus.req_in_op | {NUM_REQ{rsv_avail}});

    always_comb begin
        int   idx;
        idx_t cand;
        logic found;
        idx     = 0;
        cand    = '0;
        found   = 1'b0;
        win     = ptr_q;
        gnt     = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx  = (int'(ptr_q) + k) % int'(NUM_REQ);
            cand = idx_t'(idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        // Grants are suppressed while reset is asserted so every output reads 0.
        gnt_vld = found && stage_free && rst_;
        if (gnt_vld) gnt[win] = 1'b1;
    end

    always_comb begin
        win_data = bus.req_in_data[32*int'(win) +: 32];
        win_addr = bus.req_in_addr[16*int'(win) +: 16];
        win_wben = bus.req_in_wben[4*int'(win) +: 4];
        win_op   = bus.req_in_op[win];
    end

    assign rsv_inc    = gnt_vld && !win_op;
    assign fifo_empty = (wr_q == rd_q);
    // ptr_q always names the owner of the stage: both change only on a grant.
    assign push       = vld_q && bus.mem_in_rtr && !op_q;
    assign pop        = bus.mem_in_rvalid && !fifo_empty;
    assign head       = tag_mem[rd_q[PTR_W-1:0]];

    always_comb begin
        rsv_d    = rsv_q + CNT_W'(rsv_inc) - CNT_W'(pop);
        rvalid_d = '0;
        if (pop) rvalid_d[head] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr_q  <= idx_t'(NUM_REQ - 1);
            rsv_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
            wben_q <= '0;
            op_q   <= 1'b0;
        end else begin
            rsv_q <= rsv_d;
            if (gnt_vld) begin
                ptr_q  <= win;
                vld_q  <= 1'b1;
                data_q <= win_data;
                addr_q <= win_addr;
                wben_q <= win_op ? win_wben : 4'h0;
                op_q   <= win_op;
            end else if (bus.mem_in_rtr) begin
                vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_q     <= '0;
            rd_q     <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q    <= rd_q + 1'b1;
                rdata_q <= bus.mem_in_rdata;
            end
            rvalid_q <= rvalid_d;
            if (bus.mem_in_rvalid && fifo_empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_q[PTR_W-1:0]] <= ptr_q;
    end

    assign bus.req_out_rtr    = gnt;
    assign bus.req_out_rvalid = rvalid_q;
    assign bus.req_out_rdata  = rdata_q;
    assign bus.mem_out_data   = data_q;
    assign bus.mem_out_addr   = addr_q;
    assign bus.mem_out_wben   = wben_q;
    assign bus.mem_out_op     = op_q;
    assign bus.mem_out_rts    = vld_q;
    assign bus.arb_err        = err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: scoreboard of memory transfers and read returns
// plus per-scenario grant/handshake checks.
module tb_vram_arbiter;

    localparam int NR = 3;
    localparam int TD = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] addr;
        logic [3:0]  wben;
        logic        op;
    } mem_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    vram_arbiter_if #(.NUM_REQ(NR)) bus ();

    vram_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    logic [31:0] r_data [NR];
    logic [15:0] r_addr [NR];
    logic [3:0]  r_wben [NR];
    logic        r_op   [NR];
    logic        r_rts  [NR];

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bus.req_in_data[i*32 +: 32] = r_data[i];
            bus.req_in_addr[i*16 +: 16] = r_addr[i];
            bus.req_in_wben[i*4 +: 4]   = r_wben[i];
            bus.req_in_op[i]            = r_op[i];
            bus.req_in_rts[i]           = r_rts[i];
        end
    end

    mem_t exp_mem [$];
    rd_t  exp_rd  [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_t mon_got, mon_want;
    rd_t  mon_rd;
    logic [NR-1:0] mon_oh;

    function automatic mem_t req_txn(input int i);
        return {r_data[i], r_addr[i], (r_op[i] ? r_wben[i] : 4'h0), r_op[i]};
    endfunction

    // Scoreboard: every memory-side transfer and every read return is checked in order.
    always @(negedge clk) begin
        if (rst_ === 1'b1) begin
            if (bus.mem_out_rts && bus.mem_in_rtr) begin
                mon_got = {bus.mem_out_data, bus.mem_out_addr, bus.mem_out_wben, bus.mem_out_op};
                n_cmp++;
                if (exp_mem.size() == 0) begin
                    n_bad++;
                    $display("FAIL mem_xfer: got %h, required no transfer", mon_got);
                end else begin
                    mon_want = exp_mem.pop_front();
                    if (mon_got !== mon_want) begin
                        n_bad++;
                        $display("FAIL mem_xfer: got %h, required %h", mon_got, mon_want);
                    end
                end
            end
            if (bus.req_out_rvalid !== '0) begin
                n_cmp++;
                if (exp_rd.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_return: got rvalid %b data %h, required none",
                             bus.req_out_rvalid, bus.req_out_rdata);
                end else begin
                    mon_rd = exp_rd.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_rd.idx] = 1'b1;
                    if (bus.req_out_rvalid !== mon_oh || bus.req_out_rdata !== mon_rd.data) begin
                        n_bad++;
                        $display("FAIL rd_return: got rvalid %b data %h, required %b data %h",
                                 bus.req_out_rvalid, bus.req_out_rdata, mon_oh, mon_rd.data);
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        for (int i = 0; i < NR; i++) begin
            r_data[i] = '0;
            r_addr[i] = '0;
            r_wben[i] = '0;
            r_op[i]   = 1'b0;
            r_rts[i]  = 1'b0;
        end
        bus.mem_in_rtr    = 1'b0;
        bus.mem_in_rdata  = '0;
        bus.mem_in_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        exp_mem.delete();
        exp_rd.delete();
        #1 rst_ = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_mem.size() != 0 || exp_rd.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (exp_mem.size() != 0 || exp_rd.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d mem / %0d rd pending, required 0",
                     name, exp_mem.size(), exp_rd.size());
        end
    endtask

    task automatic test_reset();
        logic [92:0] outs;
        rst_ = 1'b0;
        for (int i = 0; i < NR; i++) begin
            r_rts[i]  = 1'b1;
            r_op[i]   = 1'b1;
            r_wben[i] = 4'hF;
            r_addr[i] = 16'h0010 + 16'(i);
            r_data[i] = 32'hC0000000 + 32'(i);
        end
        bus.mem_in_rtr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            outs = {bus.req_out_rtr, bus.req_out_rvalid, bus.req_out_rdata, bus.mem_out_data,
                    bus.mem_out_addr, bus.mem_out_wben, bus.mem_out_op, bus.mem_out_rts,
                    bus.arb_err};
            n_cmp++;
            if (outs !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h, required 0", outs);
            end
        end
        @(posedge clk);
        #1 rst_ = 1'b1;
        exp_mem.push_back(req_txn(0));
        @(negedge clk);
        n_cmp++;
        if (bus.req_out_rtr !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_first_grant: got %b, required 001", bus.req_out_rtr);
        end
        @(posedge clk);
        #1 for (int i = 0; i < NR; i++) r_rts[i] = 1'b0;
        wait_drain("reset");
    endtask

    task automatic test_single_stream();
        logic [NR-1:0] want_rtr;
        logic          want_rts;
        do_reset();
        bus.mem_in_rtr = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c < 4) begin
                r_rts[0]  = 1'b1;
                r_op[0]   = 1'b1;
                r_wben[0] = 4'hF;
                r_addr[0] = 16'h0020 + 16'(c);
                r_data[0] = 32'h01020304 + 32'(c) * 32'h04040404;
                exp_mem.push_back(req_txn(0));
            end else begin
                r_rts[0] = 1'b0;
            end
            @(negedge clk);
            want_rtr = (c < 4) ? 3'b001 : 3'b000;
            want_rts = (c >= 1 && c <= 4);
            n_cmp++;
            if (bus.req_out_rtr !== want_rtr || bus.mem_out_rts !== want_rts) begin
                n_bad++;
                $display("FAIL single_stream c%0d: got rtr %b rts %b, required rtr %b rts %b",
                         c, bus.req_out_rtr, bus.mem_out_rts, want_rtr, want_rts);
            end
        end
        wait_drain("single_stream");
    endtask

    task automatic test_contention();
        int cnt [NR];
        int want;
        do_reset();
        bus.mem_in_rtr = 1'b1;
        for (int i = 0; i < NR; i++) begin
            cnt[i]    = 0;
            r_op[i]   = 1'b1;
            r_wben[i] = 4'hF;
            r_addr[i] = 16'h0100 * 16'(i + 1);
            r_data[i] = 32'hA0000000 | (32'(i) << 16);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c > 0) begin
                want = (c - 1) % NR;
                r_addr[want] = r_addr[want] + 16'd1;
                r_data[want] = r_data[want] + 32'd1;
            end
            for (int i = 0; i < NR; i++) r_rts[i] = 1'b1;
            want = c % NR;
            exp_mem.push_back(req_txn(want));
            @(negedge clk);
            for (int i = 0; i < NR; i++) cnt[i] += int'(bus.req_out_rtr[i]);
            n_cmp++;
            if (bus.req_out_rtr !== (3'b001 << want)) begin
                n_bad++;
                $display("FAIL contention c%0d: got %b, required %b",
                         c, bus.req_out_rtr, 3'b001 << want);
            end
        end
        for (int i = 0; i < NR; i++) begin
            n_cmp++;
            if (cnt[i] != 2) begin
                n_bad++;
                $display("FAIL contention_share req%0d: got %0d grants, required 2", i, cnt[i]);
            end
        end
        @(posedge clk);
        #1 for (int i = 0; i < NR; i++) r_rts[i] = 1'b0;
        wait_drain("contention");
    endtask

    task automatic test_backpressure();
        int   sent;
        logic stall;
        mem_t stage;
        do_reset();
        sent      = 0;
        r_op[0]   = 1'b1;
        r_wben[0] = 4'hF;
        for (int c = 0; c < 30 && sent < 8; c++) begin
            @(posedge clk);
            #1;
            stall          = (c >= 3 && c < 8);
            bus.mem_in_rtr = !stall;
            r_rts[0]       = 1'b1;
            r_addr[0]      = 16'h0400 + 16'(sent);
            r_data[0]      = 32'h5A000000 + 32'(sent);
            @(negedge clk);
            n_cmp++;
            if (bus.req_out_rtr !== {2'b00, !stall}) begin
                n_bad++;
                $display("FAIL backpressure_rtr c%0d: got %b, required %b",
                         c, bus.req_out_rtr, {2'b00, !stall});
            end
            if (stall && exp_mem.size() != 0) begin
                stage = {bus.mem_out_data, bus.mem_out_addr, bus.mem_out_wben, bus.mem_out_op};
                n_cmp++;
                if (stage !== exp_mem[0] || bus.mem_out_rts !== 1'b1) begin
                    n_bad++;
                    $display("FAIL backpressure_hold c%0d: got %h rts %b, required %h rts 1",
                             c, stage, bus.mem_out_rts, exp_mem[0]);
                end
            end
            if (bus.req_out_rtr[0] && r_rts[0]) begin
                exp_mem.push_back(req_txn(0));
                sent++;
            end
        end
        @(posedge clk);
        #1;
        r_rts[0]       = 1'b0;
        bus.mem_in_rtr = 1'b1;
        n_cmp++;
        if (sent != 8) begin
            n_bad++;
            $display("FAIL backpressure_sent: got %0d, required 8", sent);
        end
        wait_drain("backpressure");
    endtask

    task automatic test_read_routing();
        do_reset();
        bus.mem_in_rtr = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i < 3; i++) begin
            r_op[i]   = 1'b0;
            r_wben[i] = 4'hF;
            r_addr[i] = 16'h0100 * 16'(i);
            r_data[i] = 32'hDEAD0000 + 32'(i);
            r_rts[i]  = 1'b1;
        end
        exp_mem.push_back({32'hDEAD0001, 16'h0100, 4'h0, 1'b0});
        exp_mem.push_back({32'hDEAD0002, 16'h0200, 4'h0, 1'b0});
        exp_rd.push_back({8'd1, 32'hAAAA5555});
        exp_rd.push_back({8'd2, 32'h12345678});
        @(negedge clk);
        n_cmp++;
        if (bus.req_out_rtr !== 3'b010) begin
            n_bad++;
            $display("FAIL read_grant1: got %b, required 010", bus.req_out_rtr);
        end
        @(posedge clk);
        #1 r_rts[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.req_out_rtr !== 3'b100 || bus.mem_out_wben !== 4'h0) begin
            n_bad++;
            $display("FAIL read_grant2: got rtr %b wben %h, required rtr 100 wben 0",
                     bus.req_out_rtr, bus.mem_out_wben);
        end
        @(posedge clk);
        #1 r_rts[2] = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_in_rvalid = 1'b1;
        bus.mem_in_rdata  = 32'hAAAA5555;
        @(posedge clk);
        #1 bus.mem_in_rdata = 32'h12345678;
        @(posedge clk);
        #1 bus.mem_in_rvalid = 1'b0;
        wait_drain("read_routing");
    endtask

    task automatic test_tag_full();
        int order [13];
        int want;
        order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1};
        do_reset();
        bus.mem_in_rtr = 1'b1;
        r_op[0] = 1'b1;  r_wben[0] = 4'hF; r_addr[0] = 16'h0500; r_data[0] = 32'h77000000;
        r_op[1] = 1'b0;  r_wben[1] = 4'hF; r_addr[1] = 16'h0300; r_data[1] = 32'h11110000;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk);
            #1;
            if (c > 0) begin
                want = order[c-1];
                r_addr[want] = r_addr[want] + 16'd1;
                r_data[want] = r_data[want] + 32'd1;
            end
            r_rts[0] = 1'b1;
            r_rts[1] = 1'b1;
            if (c == 11) begin
                bus.mem_in_rvalid = 1'b1;
                bus.mem_in_rdata  = 32'hC0DE0000;
                exp_rd.push_back({8'd1, 32'hC0DE0000});
            end else begin
                bus.mem_in_rvalid = 1'b0;
            end
            exp_mem.push_back(req_txn(order[c]));
            @(negedge clk);
            n_cmp++;
            if (bus.req_out_rtr !== (3'b001 << order[c])) begin
                n_bad++;
                $display("FAIL tag_full_grant c%0d: got %b, required %b",
                         c, bus.req_out_rtr, 3'b001 << order[c]);
            end
        end
        @(posedge clk);
        #1;
        r_rts[0]          = 1'b0;
        r_rts[1]          = 1'b0;
        bus.mem_in_rvalid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            bus.mem_in_rvalid = 1'b1;
            bus.mem_in_rdata  = 32'hC0DE0000 + 32'(k);
            exp_rd.push_back({8'd1, 32'hC0DE0000 + 32'(k)});
        end
        @(posedge clk);
        #1 bus.mem_in_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.arb_err !== 1'b0) begin
            n_bad++;
            $display("FAIL arb_err_clear: got %b, required 0", bus.arb_err);
        end
        @(posedge clk);
        #1;
        bus.mem_in_rvalid = 1'b1;
        bus.mem_in_rdata  = 32'hBAD0BAD0;
        @(posedge clk);
        #1 bus.mem_in_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (bus.arb_err !== 1'b1 || bus.req_out_rvalid !== '0) begin
                n_bad++;
                $display("FAIL arb_err_sticky: got err %b rvalid %b, required err 1 rvalid 000",
                         bus.arb_err, bus.req_out_rvalid);
            end
        end
        wait_drain("tag_full");
    endtask

    initial begin
        rst_ = 1'b0;
        clear_inputs();
        test_reset();
        test_single_stream();
        test_contention();
        test_backpressure();
        test_read_routing();
        test_tag_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
